// File: rtl/dc_accel_fifo_if.sv
// dc_accel_fifo_if: router/accelerator put-get bundle (master = router and accelerator side, slave = FIFO)
interface dc_accel_fifo_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
);
  logic              put_req;
  logic [WIDTH-1:0]  data_in;
  logic              get_req;
  logic              err_clr;
  logic [WIDTH-1:0]  data_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  modport master (
    output put_req, data_in, get_req, err_clr,
    input  data_out, data_valid, full, empty, count, overflow, underflow
  );
  modport slave (
    input  put_req, data_in, get_req, err_clr,
    output data_out, data_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/dc_accel_fifo.sv
// dc_accel_fifo: registered put/get receive FIFO with sticky overflow/underflow flags
// Ports: clk, reset (async, active-low), bus (slave modport): put_req/data_in/get_req/err_clr in;
// data_out/data_valid/full/empty/count/overflow/underflow out, all registered.
module dc_accel_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic            clk,
  input logic            reset,
  dc_accel_fifo_if.slave bus
);
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              put_acc, get_acc;
  logic [ADDR_W:0]   count_nxt;
  assign put_acc   = bus.put_req & ~bus.full;
  assign get_acc   = bus.get_req & ~bus.empty;
  assign count_nxt = bus.count + (ADDR_W+1)'(put_acc) - (ADDR_W+1)'(get_acc);
  always_ff @(posedge clk) begin
    if (put_acc) mem[wr_ptr] <= bus.data_in;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bus.count      <= '0;
      bus.empty      <= 1'b1;
      bus.full       <= 1'b0;
      bus.data_valid <= 1'b0;
      bus.data_out   <= '0;
      bus.overflow   <= 1'b0;
      bus.underflow  <= 1'b0;
    end else begin
      wr_ptr         <= put_acc ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr         <= get_acc ? rd_ptr + 1'b1 : rd_ptr;
      bus.count      <= count_nxt;
      bus.empty      <= count_nxt == '0;
      bus.full       <= count_nxt == (ADDR_W+1)'(DEPTH);
      bus.data_valid <= get_acc;
      bus.data_out   <= get_acc ? mem[rd_ptr] : bus.data_out;
      bus.overflow   <= (bus.put_req & bus.full) | (bus.overflow & ~bus.err_clr);
      bus.underflow  <= (bus.get_req & bus.empty) | (bus.underflow & ~bus.err_clr);
    end
  end
endmodule

// File: tb/tb_dc_accel_fifo.sv
// tb_dc_accel_fifo: scoreboard bench for dc_accel_fifo against a queue model
module tb_dc_accel_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int ADDR_W = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] exp_q [$];
  logic m_ovf = 1'b0, m_unf = 1'b0, m_valid = 1'b0;
  logic [WIDTH-1:0] m_out = '0;
  dc_accel_fifo_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
  dc_accel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_valid = 1'b0;
    m_out = '0;
  endtask
  task automatic cycle(input logic p, input logic [31:0] d, input logic g, input logic c);
    bit was_full, was_empty;
    bus.put_req = p;
    bus.data_in = d;
    bus.get_req = g;
    bus.err_clr = c;
    @(posedge clk);
    was_full  = q.size() == DEPTH;
    was_empty = q.size() == 0;
    m_ovf = (p && was_full) || (m_ovf && !c);
    m_unf = (g && was_empty) || (m_unf && !c);
    m_valid = g && !was_empty;
    if (m_valid) begin
      m_out = q.pop_front();
      exp_q.push_back(m_out);
    end
    if (p && !was_full) q.push_back(d);
    @(negedge clk);
    bus.put_req = 1'b0;
    bus.get_req = 1'b0;
    bus.err_clr = 1'b0;
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.data_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(bus.data_valid), 32'd0);
        else chk("data_out", bus.data_out, exp_q.pop_front());
      end else begin
        chk("data_hold", bus.data_out, m_out);
      end
      chk("data_valid", 32'(bus.data_valid), 32'(m_valid));
      chk("count", 32'(bus.count), 32'(q.size()));
      chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_unf));
    end
  end
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
    chk({tag, "_full"}, 32'(bus.full), 32'd0);
    chk({tag, "_count"}, 32'(bus.count), 32'd0);
    chk({tag, "_data_out"}, bus.data_out, 32'd0);
    chk({tag, "_data_valid"}, 32'(bus.data_valid), 32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    chk({tag, "_underflow"}, 32'(bus.underflow), 32'd0);
  endtask
  initial begin
    bus.put_req = 1'b0;
    bus.get_req = 1'b0;
    bus.err_clr = 1'b0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'(122 + i), 1'b0, 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("ovf_count", 32'(bus.count), 32'd8);
    cycle(1'b1, 32'hBEEF, 1'b1, 1'b0);
    chk("ovf_simul_count", 32'(bus.count), 32'd7);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("unf_set", 32'(bus.underflow), 32'd1);
    cycle(1'b1, 32'd123, 1'b1, 1'b0);
    chk("unf_simul_count", 32'(bus.count), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("unf_read", bus.data_out, 32'd123);
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    for (int i = 4; i < 24; i++) begin
      cycle(1'b1, 32'(i), 1'b1, 1'b0);
      chk("wrap_count", 32'(bus.count), 32'd4);
      chk("wrap_data", bus.data_out, 32'(i - 4));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'hAA, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("midreset");
    model_reset();
    #1 reset = 1'b1;
    cycle(1'b1, 32'd77, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("post_reset_read", bus.data_out, 32'd77);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dc_accel_fifo.md
# dc_accel_fifo

Accelerator-side receive FIFO terminating the router's put/get request interface toward the FFT and FIR blocks. The data & control router writes words with `put_req` and `data_in`, then watches `full`/`empty`. The accelerator drains words with `get_req` and receives them on `data_out`/`data_valid`. Two instances are used per accelerator, one per direction: to-accelerator and from-accelerator.

## Interface
- `WIDTH`, default 32: data word width in bits.
- `DEPTH`, default 16: number of entries. Must be a power of 2 and ≥ 2.
- `ADDR_W`, default 4: log2(`DEPTH`). The integrator sets it consistently with `DEPTH`.

- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `put_req`  in  1: write request, sampled on the rising edge.
- `data_in`  in  `WIDTH`: write data, valid when `put_req`=1.
- `get_req`  in  1: read request, sampled on the rising edge.
- `err_clr`  in  1: synchronous clear of the sticky error flags.
- `data_out`  out  `WIDTH`: read data (registered).
- `data_valid`  out  1: one-cycle pulse, `data_out` updated this cycle.
- `full`  out  1: `count` == `DEPTH`.
- `empty`  out  1: `count` == 0.
- `count`  out  `ADDR_W`+1: current occupancy, 0..`DEPTH`.
- `overflow`  out  1: sticky, set by a put while full.
- `underflow`  out  1: sticky, set by a get while empty.

## Operation
- Storage is a `DEPTH` x `WIDTH` register array.
- `wr_ptr` and `rd_ptr` are each `ADDR_W` bits and wrap modulo `DEPTH` naturally: `DEPTH`-1 + 1 = 0.
- Accept rules are evaluated on registered flags at the edge:
  - put_acc = `put_req` & ~`full`
  - get_acc = `get_req` & ~`empty`
- When put_acc is asserted: mem[`wr_ptr`] <= `data_in`, and `wr_ptr` increments.
- When get_acc is asserted: `data_out` <= mem[`rd_ptr`], `rd_ptr` increments, and `data_valid` <= 1. Otherwise `data_valid` <= 0 and `data_out` holds its last value.
- `count` update:
  - +1 on put_acc only.
  - −1 on get_acc only.
  - Unchanged when both are accepted or neither is.
- `full` and `empty` are registered. They are computed from next-`count` and update on the same edge as `count`.
- Simultaneous events:
  - Full with put+get: the get is accepted and the put is rejected. `overflow` sets and `count` becomes `DEPTH`−1.
  - Empty with put+get: the put is accepted and the get is rejected. There is no fall-through. `underflow` sets and `count` becomes 1.
  - Partially filled with put+get: both are accepted and `count` is unchanged. A read and a write to the same slot cannot occur (that only happens when empty or full, covered above).
- Sticky error flags:
  - `overflow` <= 1 when `put_req` & `full`.
  - `underflow` <= 1 when `get_req` & `empty`.
  - Both are cleared when `err_clr`=1. If set and clear happen in the same cycle, set wins.
  - Rejected requests change no other state.
- Reset, asynchronous, when `reset`=0:
  - Pointers = 0, `count` = 0, `empty` = 1, `full` = 0.
  - `data_valid` = 0, `data_out` = 0, `overflow` = 0, `underflow` = 0.
  - Memory contents are not reset.
  - Reset mid-transfer discards all contents immediately. The first edge after `reset` deasserts behaves as on an empty FIFO.

## Timing
- Write-to-flag latency: a put accepted at edge N makes `empty`=0 and `count`=1 visible after edge N.
- Earliest read: a get presented at edge N+1 is accepted.
- Read latency: 1 cycle. A get accepted at edge N yields `data_out` and `data_valid`=1 after edge N, for one cycle.
- Throughput: one put and one get per cycle, sustained.
- `full` deasserts after the edge of the first get accepted while full. A put at the next edge is then accepted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use `DEPTH`=8, `WIDTH`=32.
- Reset: hold `reset`=0 for 3 cycles -> `empty`=1, `full`=0, `count`=0, `data_out`=0, `data_valid`=0, `overflow`=0, `underflow`=0.
- Fill/drain order:
  - Put 8 words 122..129 on consecutive cycles -> `full`=1 after the 8th edge, `count`=8.
  - Then get 8 -> `data_out` = 122..129 in order with `data_valid`=1 each cycle, `empty`=1 and `count`=0 at the end.
- Overflow/full-simultaneous:
  - At `count`=8, `put_req`=1 with `data_in`=0xDEAD -> `overflow`=1, `count` stays 8, and 0xDEAD is never read.
  - Next, put+get together -> `count`=7, `overflow` stays 1.
  - `err_clr`=1 -> `overflow`=0.
- Underflow/empty-simultaneous:
  - On empty, `get_req`=1 -> `underflow`=1, `data_valid`=0, `data_out` unchanged.
  - On empty, put 123 + get together -> `count`=1, `underflow`=1.
  - Next get -> `data_out`=123.
- Wrap-around streaming: 20 cycles of put+get with 4 entries preloaded (values 0..23 in total) -> `count` constant at 4, output sequence 0..19 with no gaps, pointers wrap twice.
- Reset mid-operation: with `count`=5, pulse `reset` low asynchronously between edges -> outputs go to reset values immediately. A following put of 77 then get returns 77.
